uart_rx_core: RTL

Parametrised UART receive core; successor to the fixed 8N1 receiver used by the serial link into the game logic. Runs entirely on the system clock: no derived baud clock, with a synchronised and majority-voted RX line. Supports configurable data width, parity and stop bits, and buffers received frames in a small FIFO. Frames and their per-frame error flags are delivered on a valid/ready interface.

---
 rtl/uart_rx_core.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receiver with a 2-flop synchroniser, 3-sample majority vote per bit,
// configurable frame format and a small frame FIFO on a valid/ready output.
module uart_rx_core #(
    parameter int CLOCK_PER_BIT = 54,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLOCK_PER_BIT);
    localparam int H  = CLOCK_PER_BIT / 2;
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic                 sync1_reg, sync2_reg, prev_reg;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic                 s0_reg, s0_next, s1_reg, s1_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 perr_reg, perr_next, ferr_reg, ferr_next;
    logic                 push;
    logic [EW-1:0]        push_entry;

    logic                 synced, decide, bit_val, par_exp;
    logic [CW-1:0]        cnt_step;

    assign synced   = sync2_reg;
    assign decide   = (cnt_reg == CNT_DEC);
    assign bit_val  = (s0_reg & s1_reg) | (s0_reg & synced) | (s1_reg & synced);
    assign par_exp  = (PARITY == 2) ? (^data_reg) : ~(^data_reg);
    assign cnt_step = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            prev_reg     <= 1'b1;
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            s0_reg       <= 1'b1;
            s1_reg       <= 1'b1;
            data_reg     <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            sync1_reg    <= in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            stop_idx_reg <= stop_idx_next;
            s0_reg       <= s0_next;
            s1_reg       <= s1_next;
            data_reg     <= data_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = (state_reg == S_IDLE) ? '0 : cnt_step;
        idx_next      = idx_reg;
        stop_idx_next = stop_idx_reg;
        s0_next       = (cnt_reg == CNT_S0) ? synced : s0_reg;
        s1_next       = (cnt_reg == CNT_S1) ? synced : s1_reg;
        data_next     = data_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        push          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!synced && prev_reg) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            S_START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_DATA;
                        idx_next   = '0;
                        data_next  = '0;
                        perr_next  = 1'b0;
                        ferr_next  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    data_next[idx_reg] = bit_val;
                    if (idx_reg == IDX_LAST) begin
                        state_next    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_next = 1'b0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_next  = (bit_val != par_exp);
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_next = ferr_reg | ~bit_val;
                    if (stop_idx_reg == STOP_LAST) begin
                        // Push at mid-stop so back-to-back frames never lose a start edge.
                        push       = 1'b1;
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign push_entry = {data_reg, perr_reg, ferr_next};
    assign busy       = (state_reg != S_IDLE);

    logic [EW-1:0] mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overrun_reg;
    logic          pop, full, push_ok;
    logic [EW-1:0] head;

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count_reg == FULL_COUNT);
    assign push_ok   = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= push & full & ~pop;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_entry;
    end

    assign head          = mem_reg[rd_ptr_reg];
    assign out_data      = out_valid ? head[EW-1:2] : '0;
    assign parity_error  = out_valid & head[1];
    assign framing_error = out_valid & head[0];
    assign overrun       = overrun_reg;

endmodule
